// File: rtl/hazard_resolver.sv
// Hazard resolver: turns decode-stage RAW hazard flags and EX/MEM status into
// stall, flush, bubble and forwarding-select controls for a 5-stage pipeline.
module hazard_resolver #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       raw_hazards_i,
  input  logic             load_ex_i,
  input  logic             branch_taken_ex_i,
  input  logic             mem_busy_i,
  output logic             stall_pc_o,
  output logic             stall_dec_o,
  output logic             stall_ex_o,
  output logic             stall_mem_o,
  output logic             flush_dec_o,
  output logic             bubble_ex_o,
  output logic [1:0]       fwd_a_sel_o,
  output logic [1:0]       fwd_b_sel_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam int unsigned LCNT_W = 2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  state_e              saved_q, saved_d;
  state_e              eff_state;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
  logic [1:0]          fwd_a_q, fwd_a_d;
  logic [1:0]          fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                load_use;
  logic                stall_front, stall_back, flush_c, bubble_c;

  // Next-state, forwarding and control decode with priority mem_busy > branch > load-use > normal
  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    lcnt_d      = lcnt_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_front = 1'b0;
    stall_back  = 1'b0;
    flush_c     = 1'b0;
    bubble_c    = 1'b0;
    // While frozen the saved state is what resumes as soon as memory is ready
    eff_state   = (state_q == MEM_WAIT) ? saved_q : state_q;
    load_use    = load_ex_i & (raw_hazards_i[0] | raw_hazards_i[2]);

    if (mem_busy_i) begin
      stall_front = 1'b1;
      stall_back  = 1'b1;
      state_d     = MEM_WAIT;
      saved_d     = eff_state;
    end else if (branch_taken_ex_i) begin
      flush_c  = 1'b1;
      bubble_c = 1'b1;
      fwd_a_d  = FWD_RF;
      fwd_b_d  = FWD_RF;
      lcnt_d   = '0;
      state_d  = RUN;
    end else if (eff_state == LOAD_STALL) begin
      stall_front = 1'b1;
      bubble_c    = 1'b1;
      fwd_a_d     = FWD_RF;
      fwd_b_d     = FWD_RF;
      lcnt_d      = lcnt_q - LCNT_W'(1);
      state_d     = (lcnt_q == LCNT_W'(1)) ? RUN : LOAD_STALL;
    end else if (load_use) begin
      stall_front = 1'b1;
      bubble_c    = 1'b1;
      fwd_a_d     = FWD_RF;
      fwd_b_d     = FWD_RF;
      if (LOAD_LAT > 1) begin
        state_d = LOAD_STALL;
        lcnt_d  = LCNT_W'(LOAD_LAT - 1);
      end else begin
        state_d = RUN;
      end
    end else begin
      state_d = RUN;
      // Youngest producer (EX) wins over the older one (MEM)
      fwd_a_d = raw_hazards_i[0] ? FWD_MEM : (raw_hazards_i[1] ? FWD_WB : FWD_RF);
      fwd_b_d = raw_hazards_i[2] ? FWD_MEM : (raw_hazards_i[3] ? FWD_WB : FWD_RF);
    end

    cnt_d = (stall_front && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // State, saved state, load counter, forwarding selects and stall counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      saved_q <= RUN;
      lcnt_q  <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      lcnt_q  <= lcnt_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  // Controls are forced quiet while reset is asserted
  assign stall_pc_o     = stall_front & ~rst_i;
  assign stall_dec_o    = stall_front & ~rst_i;
  assign stall_ex_o     = stall_back  & ~rst_i;
  assign stall_mem_o    = stall_back  & ~rst_i;
  assign flush_dec_o    = flush_c     & ~rst_i;
  assign bubble_ex_o    = bubble_c    & ~rst_i;
  assign fwd_a_sel_o    = fwd_a_q;
  assign fwd_b_sel_o    = fwd_b_q;
  assign stall_cycles_o = cnt_q;

endmodule

// File: tb/tb_hazard_resolver.sv
// Bench for hazard_resolver: three instances (LOAD_LAT 1/2/3, narrow and wide
// counters) share one stimulus stream; expectations come from a queue-fed model.
module tb_hazard_resolver;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst     = 1'b1;
  logic [3:0] rh      = 4'b0000;
  logic       load_ex = 1'b0;
  logic       br      = 1'b0;
  logic       mb      = 1'b1;

  logic [NI-1:0][5:0]  ctl;
  logic [NI-1:0][3:0]  fwd;
  logic [NI-1:0][15:0] sc;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned CW = (g == 0) ? 16 : ((g == 1) ? 4 : 6);
    logic sp, sd, se, sm, fd, bx;
    logic [1:0] a, b;
    logic [CW-1:0] c;
    hazard_resolver #(.LOAD_LAT(g + 1), .CNT_W(CW)) u_dut (
      .clk_i(clk), .rst_i(rst), .raw_hazards_i(rh), .load_ex_i(load_ex),
      .branch_taken_ex_i(br), .mem_busy_i(mb),
      .stall_pc_o(sp), .stall_dec_o(sd), .stall_ex_o(se), .stall_mem_o(sm),
      .flush_dec_o(fd), .bubble_ex_o(bx), .fwd_a_sel_o(a), .fwd_b_sel_o(b),
      .stall_cycles_o(c));
    assign ctl[g] = {sp, sd, se, sm, fd, bx};
    assign fwd[g] = {a, b};
    assign sc[g]  = 16'(c);
  end

  typedef struct {
    int          inst;
    logic [5:0]  ctl;
    logic [3:0]  fwd;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: remaining load bubbles as a plain count; a busy memory just freezes everything
  int         rem  [NI];
  logic [1:0] mfa  [NI];
  logic [1:0] mfb  [NI];
  int         mcnt [NI];

  function automatic int cmax(input int i);
    int w;
    w = (i == 0) ? 16 : ((i == 1) ? 4 : 6);
    return (1 << w) - 1;
  endfunction

  function automatic logic [1:0] pick(input logic ex_m, input logic mem_m);
    if (ex_m) return 2'b01;
    if (mem_m) return 2'b10;
    return 2'b00;
  endfunction

  // Apply one cycle of inputs, push expectations, then advance the model past the next edge
  task automatic step(input logic r, input logic [3:0] h, input logic l, input logic b, input logic m);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; rh = h; load_ex = l; br = b; mb = m;
    for (int i = 0; i < NI; i++) begin
      e.inst = i;
      e.fwd  = {mfa[i], mfb[i]};
      e.cnt  = 16'(mcnt[i]);
      if (r) begin
        e.ctl = 6'b000000;
        rem[i] = 0; mfa[i] = 2'b00; mfb[i] = 2'b00; mcnt[i] = 0;
      end else begin
        if (m) begin
          e.ctl = 6'b111100;
        end else if (b) begin
          e.ctl = 6'b000011;
          rem[i] = 0; mfa[i] = 2'b00; mfb[i] = 2'b00;
        end else if (rem[i] > 0) begin
          e.ctl = 6'b110001;
          rem[i] = rem[i] - 1; mfa[i] = 2'b00; mfb[i] = 2'b00;
        end else if (l && (h[0] || h[2])) begin
          e.ctl = 6'b110001;
          rem[i] = i; mfa[i] = 2'b00; mfb[i] = 2'b00;
        end else begin
          e.ctl = 6'b000000;
          mfa[i] = pick(h[0], h[1]);
          mfb[i] = pick(h[2], h[3]);
        end
        if (e.ctl[5] && mcnt[i] < cmax(i)) mcnt[i] = mcnt[i] + 1;
      end
      q.push_back(e);
    end
  endtask

  // Monitor: every cycle presents a full output set, compare it against queued expectations
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (ctl[e.inst] !== e.ctl) begin
        errors++;
        $display("FAIL ctl inst%0d t=%0t got %b want %b", e.inst, $time, ctl[e.inst], e.ctl);
      end
      checks++;
      if (fwd[e.inst] !== e.fwd) begin
        errors++;
        $display("FAIL fwd inst%0d t=%0t got %b want %b", e.inst, $time, fwd[e.inst], e.fwd);
      end
      checks++;
      if (sc[e.inst] !== e.cnt) begin
        errors++;
        $display("FAIL stall_cycles inst%0d t=%0t got %0d want %0d", e.inst, $time, sc[e.inst], e.cnt);
      end
    end
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      rem[i] = 0; mfa[i] = 2'b00; mfb[i] = 2'b00; mcnt[i] = 0;
    end
    // Reset held with mem_busy asserted
    step(1, 4'b0000, 0, 0, 1);
    step(1, 4'b0000, 0, 0, 1);
    // Forwarding patterns
    step(0, 4'b0001, 0, 0, 0);
    step(0, 4'b1010, 0, 0, 0);
    step(0, 4'b0011, 0, 0, 0);
    step(0, 4'b0000, 0, 0, 0);
    // Load-use then consumer of the load in MEM
    step(0, 4'b0100, 1, 0, 0);
    repeat (3) step(0, 4'b1000, 0, 0, 0);
    // Load-use with a taken branch on the following cycle
    step(0, 4'b0100, 1, 0, 0);
    step(0, 4'b0000, 0, 1, 0);
    repeat (3) step(0, 4'b0000, 0, 0, 0);
    // Memory freeze in the middle of a load stall
    step(0, 4'b0001, 1, 0, 0);
    repeat (4) step(0, 4'b0101, 0, 0, 1);
    repeat (4) step(0, 4'b0010, 0, 0, 0);
    // Reset in the middle of a load stall
    step(0, 4'b0100, 1, 0, 0);
    step(1, 4'b0000, 0, 0, 0);
    step(0, 4'b0000, 0, 0, 0);
    // Long freeze drives the narrow counters into saturation
    repeat (75) step(0, 4'b0000, 0, 0, 1);
    repeat (2) step(0, 4'b0001, 0, 0, 0);
    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) == 0),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 5) == 0));
    end
    step(0, 4'b0000, 0, 0, 0);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
